bus_arb_4: RTL and testbench

- Four-requester round-robin arbiter that shares one 32-bit datapath resource (a bus or memory port) between four masters.
- It drives the 2-bit select of a 4:1 32-bit word mux and a one-hot grant vector.
- Handshake is request/done, with a per-grant hold timeout so that no master can starve the others.
- Sits between the requesting units and the shared mux in the CPU datapath.

---
 rtl/bus_arb_4_if.sv | 13 +
 rtl/bus_arb_4.sv | 108 ++++++++++
 tb/tb_bus_arb_4.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arb_4_if.sv
// Handshake bundle between the four requesting masters and the round-robin arbiter.
// The slave side is the arbiter; the master side is the requesting units.
interface bus_arb_4_if;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    modport slave  (input  req, done, output grant, sel, busy, timeout);
    modport master (output req, done, input  grant, sel, busy, timeout);
endinterface

// File: rtl/bus_arb_4.sv
// Four-way round-robin arbiter for one shared 32-bit mux port, with request/done
// handshake and a per-grant hold budget that forces release when it runs out.
module bus_arb_4 #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    bus_arb_4_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit               TO_EN = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] LIMIT = TO_EN ? CNT_W'(HOLD_MAX - 1) : '0;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_grant;
    logic [1:0]       r_sel;
    logic             r_busy;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_grant_nxt;
    logic [1:0]       w_sel_nxt;
    logic             w_to_nxt;

    logic [1:0]       w_win;
    logic             w_any_req;
    logic             w_req_o;
    logic             w_done_o;
    logic             w_limit;
    logic             w_release;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        w_win = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
        end
    end

    // Only the owner's bits are looked at in BUSY, so noise elsewhere is ignored.
    assign w_any_req = |bus.req;
    assign w_req_o   = bus.req[r_sel];
    assign w_done_o  = bus.done[r_sel];
    assign w_limit   = TO_EN && (r_cnt == LIMIT);
    assign w_release = w_done_o || !w_req_o || w_limit;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_to_nxt    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 4'b0000;
                    w_ptr_nxt   = r_sel + 2'd1;
                    w_cnt_nxt   = '0;
                    w_to_nxt    = w_limit && !w_done_o && w_req_o;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_cnt     <= '0;
            r_grant   <= 4'b0000;
            r_sel     <= 2'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_sel     <= w_sel_nxt;
            r_busy    <= |w_grant_nxt;
            r_timeout <= w_to_nxt;
        end
    end

    assign bus.grant   = r_grant;
    assign bus.sel     = r_sel;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;
endmodule

// File: tb/tb_bus_arb_4.sv
// Bench for bus_arb_4: directed phases plus random traffic, predicted by an owner/hold
// reference model and checked through an expected-output queue by a separate monitor.
module tb_bus_arb_4;
    localparam int HM = 4;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       t;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_sel   = 0;

    bus_arb_4_if bus();

    bus_arb_4 #(.HOLD_MAX(HM), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances by one edge and queues its prediction.
    task automatic step(input logic [3:0] r, input logic [3:0] d);
        exp_t e;
        int   w;
        bit   to;
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        to = 1'b0;
        if (m_owner < 0) begin
            w = -1;
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_ptr + i) % 4;
                if (w < 0 && r[c]) w = c;
            end
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_sel   = w;
            end
        end else if (d[m_owner] || !r[m_owner] || (HM != 0 && m_held == HM)) begin
            to = (HM != 0) && (m_held == HM) && !d[m_owner] && r[m_owner];
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else begin
            m_held++;
        end
        e.g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.s = 2'(m_sel);
        e.b = (m_owner >= 0);
        e.t = to;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge with a pending prediction is compared against the DUT.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.grant, bus.sel, bus.busy, bus.timeout};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL out grant/sel/busy/to got %b/%b/%b/%b expected %b/%b/%b/%b at %0t",
                             a.g, a.s, a.b, a.t, e.g, e.s, e.b, e.t, $time);
                end
            end
        end
    end

    initial begin
        logic [3:0] cur;
        logic [3:0] flip;
        logic [3:0] d;
        int         n;

        // Reset held with random inputs.
        reset    = 1'b0;
        bus.req  = 4'($urandom);
        bus.done = 4'($urandom);
        #2;
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_to", 32'(bus.timeout), 0);
        repeat (3) begin
            @(negedge clk);
            bus.req  = 4'($urandom);
            bus.done = 4'($urandom);
        end
        @(posedge clk);
        #1;
        chk("rst_clk_grant", 32'(bus.grant), 0);
        chk("rst_clk_busy", 32'(bus.busy), 0);
        @(negedge clk);
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        reset    = 1'b1;

        repeat (5) step(4'b0000, 4'b0000);

        // Single requester with a late done pulse.
        repeat (3) step(4'b0100, 4'b0000);
        step(4'b0100, 4'b0100);
        repeat (3) step(4'b0000, 4'b0000);

        // Everyone requesting; each owner finishes on its first granted cycle.
        repeat (12) begin
            d = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            step(4'b1111, d);
        end
        repeat (2) step(4'b0000, 4'b0000);

        // Single requester that never finishes: repeated forced releases.
        repeat (14) step(4'b0001, 4'b0000);
        repeat (2) step(4'b0000, 4'b0000);

        // done arrives on the very last budgeted cycle: normal release.
        repeat (12) begin
            d = (m_owner == 0 && m_held == HM) ? 4'b0001 : 4'b0000;
            step(4'b0001, d);
        end
        repeat (2) step(4'b0000, 4'b0000);

        // Owner 1 with noise from the others.
        step(4'b0010, 4'b0000);
        repeat (3) step({2'($urandom), 2'b10}, 4'b1101);
        step({2'($urandom), 2'b10}, 4'b0010);
        repeat (3) step(4'b0000, 4'b0000);

        // Sticky random traffic.
        cur = 4'b0000;
        repeat (400) begin
            flip = 4'b0000;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 5) == 0);
            cur = cur ^ flip;
            d   = 4'b0000;
            for (int b = 0; b < 4; b++) d[b] = ($urandom_range(0, 4) == 0);
            step(cur, d);
        end

        // Reset in the middle of a grant to master 3.
        n = 0;
        while (!(m_owner == 3 && m_held == 1) && n < 60) begin
            step(4'b1000, 4'b0000);
            n++;
        end
        chk("wait_owner3", 32'(m_owner), 3);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(bus.grant), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_to", 32'(bus.timeout), 0);
        chk("mid_rst_sel", 32'(bus.sel), 0);
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_sel   = 0;
        @(negedge clk);
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step(4'b1001, 4'b0000);
        repeat (3) step(4'b0000, 4'b0000);

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
